// File: rtl/mux4_arbiter_pkg.sv
// Shared types for the 4-input round-robin arbiter/mux.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mux4_arbiter_pkg;

   localparam int NUM_REQ = 4;

   // Requester index, wide enough for NUM_REQ
   typedef logic [1:0] req_idx_t;

   // IDLE: output register empty, BUSY: output register holds a word
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage : mux4_arbiter_pkg

// File: rtl/mux4_arbiter_rr_pick4.sv
// Circular priority search: first set request bit starting at ptr, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick4
   import mux4_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_idx_t           ptr,
   output logic               found,
   output req_idx_t           idx
);

   req_idx_t cand;

   // Scan from farthest to nearest offset so the nearest set bit is written last and wins
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + req_idx_t'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule : rr_pick4

// File: rtl/mux4_arbiter.sv
// Round-robin 4:1 arbiter/mux into a single registered output slot; optional grant stats (MUX4_ARBITER_STATS_EN).
// Latency: 1 cycle from accepted request to out_valid; 1 word/cycle sustained with out_ready high.
// Backpressure: out_ready low while BUSY freezes the output and holds every in_ready low.
module mux4_arbiter
   import mux4_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        in_valid,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   output logic [NUM_REQ-1:0]        in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [1:0]                out_sel,
   input  logic                      out_ready
`ifdef MUX4_ARBITER_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

   state_t      state_q, state_d;
   req_idx_t    ptr_q;
   req_idx_t    win;
   logic        found;
   logic        capture_en;
   logic        capture;
   logic [DATA_W-1:0] sel_data;

   rr_pick4 u_pick (
      .req   (in_valid),
      .ptr   (ptr_q),
      .found (found),
      .idx   (win)
   );

   // The slot can take a word when empty or when its current word leaves this cycle;
   // rst_n gates capture so nothing is accepted while reset is held
   assign capture_en = (state_q == IDLE) || out_ready;
   assign capture    = capture_en && found && rst_n;
   assign sel_data   = in_data[win*DATA_W +: DATA_W];
   assign out_valid  = (state_q == BUSY);

   // One-hot accept strobe to the winning requester
   always_comb begin
      in_ready = '0;
      if (capture) begin
         in_ready[win] = 1'b1;
      end
   end

   // Next state: fill on capture, drain when the word leaves with nothing to replace it
   always_comb begin
      state_d = state_q;
      if (capture) begin
         state_d = BUSY;
      end else if ((state_q == BUSY) && out_ready) begin
         state_d = IDLE;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output slot and rotating priority pointer load together on capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
         ptr_q    <= '0;
      end else if (capture) begin
         out_data <= sel_data;
         out_sel  <= win;
         ptr_q    <= win + req_idx_t'(1);
      end
   end

`ifdef MUX4_ARBITER_STATS_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

   // Per-requester saturating grant counters; in_ready is the one-hot capture strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (in_ready[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule : mux4_arbiter

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each requester data word.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each grant counter (used only under REQ-024).
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-005 Port in_valid SHALL be an input, 4 bits wide; bit i is the request from requester i.
REQ-006 Port in_data SHALL be an input, 4 x DATA_W bits wide, carrying the data word of each requester.
REQ-007 Port in_ready SHALL be an output, 4 bits wide; bit i accepts requester i's word, and at most one bit is high in any cycle.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, indicating that the output word is valid.
REQ-009 Port out_data SHALL be an output, DATA_W bits wide, carrying the registered selected word.
REQ-010 Port out_sel SHALL be an output, 2 bits wide, giving the requester index of out_data.
REQ-011 Port out_ready SHALL be an input, 1 bit wide, and is the downstream accept.

Function
REQ-012 States SHALL be IDLE (output register empty) and BUSY (output register holding a word).
REQ-013 Capture enable SHALL be (state==IDLE) or (state==BUSY and out_ready).
REQ-014 The winner SHALL be the first asserted in_valid bit, searching circularly from ptr, ptr+1, ... mod 4.
REQ-015 in_ready[winner] SHALL be high combinationally only when capture is enabled and any in_valid bit is high.
REQ-016 On capture, out_data and out_sel SHALL load the winner's word and index, state SHALL go to BUSY, and ptr SHALL become (winner+1) mod 4.
REQ-017 In BUSY with out_ready=1 and no in_valid bit high, the block SHALL go to IDLE; out_valid SHALL drop the next cycle.
REQ-018 In BUSY with out_ready=0, out_valid, out_data and out_sel SHALL stay stable, and all in_ready bits SHALL be 0.
REQ-019 Latency from request to out_valid SHALL be 1 cycle; sustained throughput SHALL be 1 word/cycle with out_ready held at 1.
REQ-020 With all four requesters continuously valid, grants SHALL follow 0,1,2,3,0,... and no requester SHALL wait more than 3 grants.
REQ-021 A requester SHALL hold in_valid and in_data until its in_ready; the block SHALL make no promise if a request drops before acceptance.
REQ-022 out_valid SHALL equal (state==BUSY).

Reset
REQ-023 Asserting rst_n low at any time, including mid-transfer, SHALL immediately set state=IDLE, ptr=0, out_valid=0, out_data=0, out_sel=0, and counters=0; in_ready SHALL be 0 during reset, and the word in flight SHALL be discarded.

Configuration
REQ-024 With MUX4_ARBITER_STATS_EN defined, the block SHALL add output grant_cnt (4 x CNT_W bits); entry i SHALL increment on each capture from requester i and saturate at all-ones.
REQ-025 Without MUX4_ARBITER_STATS_EN, the grant_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package mux4_arbiter_pkg SHALL hold the state enum (IDLE, BUSY), the requester-index type (2 bits), and NUM_REQ=4.
REQ-027 The circular priority search SHALL be a sub-module rr_pick4 (inputs: 4-bit request and 2-bit ptr; outputs: found and a 2-bit index), purely combinational.
REQ-028 The selection datapath SHALL be an index-driven 4:1 selection of in_data feeding the output register.

Verification
REQ-029 Single request: after reset, in_valid=0100 and in_data[2]=0xA5 -> in_ready=0100 in cycle 0; out_valid=1, out_data=0xA5, out_sel=2 in cycle 1.
REQ-030 Round robin: in_valid=1111 and out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, with exactly one in_ready bit high per cycle.
REQ-031 Backpressure: out_ready=0 for 5 cycles while BUSY -> out_data and out_sel stay constant and in_ready=0000; out_ready=1 -> the next winner is captured that same cycle.
REQ-032 Pointer skip: ptr=1, in_valid=1001 -> grant 3, then 0; ptr ends at 1.
REQ-033 Reset mid-transfer: BUSY holding 0x3C, then rst_n=0 asynchronously -> out_valid=0 immediately; after release, a request from requester 0 wins first.
REQ-034 Stats (with macro, CNT_W=2): 5 grants to requester 1 -> grant_cnt[1]=3 (saturated) and the other entries are 0.
